// File: rtl/hex_parser.sv
// ASCII hex number parser: accumulates up to MAX_DIGITS hex digits per field,
// emits the value on a terminator, flags illegal characters and overflow.
module hex_parser #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [31:0] number_out,
  output logic        number_valid,
  input  logic        number_ready,
  output logic [3:0]  digit_count,
  output logic        error
);

  // state   | meaning
  // IDLE    | between fields, waiting for the first digit
  // ACCUM   | collecting digits of a field
  // DONE    | result presented, waiting for number_ready
  // DISCARD | dropping the rest of a bad field until a terminator
  typedef enum logic [1:0] {IDLE, ACCUM, DONE, DISCARD} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_acc, w_acc_nxt;
  logic [3:0]  r_count, w_count_nxt;
  logic [31:0] r_number_out;
  logic [3:0]  r_digit_count;
  logic        r_number_valid, r_error, r_char_ready;
  logic        w_is_digit, w_is_term, w_accept, w_load, w_err;
  logic [3:0]  w_digit;

  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    if (char_in >= 8'h30 && char_in <= 8'h39) begin
      w_is_digit = 1'b1;
      w_digit    = char_in[3:0];
    end else if ((char_in >= 8'h41 && char_in <= 8'h46) ||
                 (char_in >= 8'h61 && char_in <= 8'h66)) begin
      w_is_digit = 1'b1;
      w_digit    = char_in[3:0] + 4'd9;
    end
  end

  assign w_is_term = (char_in == 8'h0D) || (char_in == 8'h0A) || (char_in == 8'h20);
  assign w_accept  = char_valid && r_char_ready;

  always_comb begin
    w_next      = r_state;
    w_acc_nxt   = r_acc;
    w_count_nxt = r_count;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_is_digit) begin
            w_acc_nxt   = {28'd0, w_digit};
            w_count_nxt = 4'd1;
            w_next      = ACCUM;
          end else if (!w_is_term) begin
            w_err  = 1'b1;
            w_next = DISCARD;
          end
        end
      end
      ACCUM: begin
        if (w_accept) begin
          if (w_is_digit) begin
            if (r_count == 4'(MAX_DIGITS)) begin
              w_err  = 1'b1;
              w_next = DISCARD;
            end else begin
              w_acc_nxt   = {r_acc[27:0], w_digit};
              w_count_nxt = r_count + 4'd1;
            end
          end else if (w_is_term) begin
            w_load      = 1'b1;
            w_acc_nxt   = 32'd0;
            w_count_nxt = 4'd0;
            w_next      = DONE;
          end else begin
            w_err  = 1'b1;
            w_next = DISCARD;
          end
        end
      end
      DONE: begin
        if (number_ready) w_next = IDLE;
      end
      DISCARD: begin
        if (w_accept && w_is_term) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_acc          <= 32'd0;
      r_count        <= 4'd0;
      r_number_out   <= 32'd0;
      r_digit_count  <= 4'd0;
      r_number_valid <= 1'b0;
      r_error        <= 1'b0;
      r_char_ready   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_acc          <= w_acc_nxt;
      r_count        <= w_count_nxt;
      r_error        <= w_err;
      r_number_valid <= (w_next == DONE);
      r_char_ready   <= (w_next != DONE);
      if (w_load) begin
        r_number_out  <= r_acc;
        r_digit_count <= r_count;
      end
    end
  end

  assign char_ready   = r_char_ready;
  assign number_out   = r_number_out;
  assign number_valid = r_number_valid;
  assign digit_count  = r_number_valid ? r_digit_count : r_count;
  assign error        = r_error;

endmodule

// File: tb/tb_hex_parser.sv
// Testbench for hex_parser: directed scenarios plus random fields checked
// every cycle against a character-stream reference model.
module tb_hex_parser;
  localparam int MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [31:0] number_out;
  logic        number_valid;
  logic        number_ready = 1'b0;
  logic [3:0]  digit_count;
  logic        error;

  hex_parser #(.MAX_DIGITS(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .number_out(number_out), .number_valid(number_valid),
    .number_ready(number_ready), .digit_count(digit_count), .error(error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_bp  = 1'b0;

  // 0..15 digit value, 16 terminator, 17 illegal
  function automatic int classify(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - int'("0");
    if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
    if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
    if (c == 8'h0D || c == 8'h0A || c == 8'h20) return 16;
    return 17;
  endfunction

  // Reference model: field-level view of the accepted character stream.
  bit          m_ready = 1'b0, m_pending = 1'b0, m_err = 1'b0, m_discard = 1'b0;
  int unsigned m_val = 0, m_out = 0;
  int          m_n = 0, m_cnt = 0, m_nres = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 0; m_pending = 0; m_err = 0; m_discard = 0;
      m_val = 0; m_n = 0;
    end else begin
      int k;
      m_err = 0;
      if (m_pending && number_ready) begin
        m_pending = 0;
      end else if (char_valid && m_ready) begin
        k = classify(char_in);
        if (m_discard) begin
          if (k == 16) m_discard = 0;
        end else if (k < 16) begin
          if (m_n == MAX) begin
            m_err = 1; m_discard = 1; m_n = 0; m_val = 0;
          end else begin
            m_val = m_val * 16 + k; m_n++;
          end
        end else if (k == 16) begin
          if (m_n > 0) begin
            m_pending = 1; m_out = m_val; m_cnt = m_n; m_nres++;
          end
          m_n = 0; m_val = 0;
        end else begin
          m_err = 1; m_discard = 1; m_n = 0; m_val = 0;
        end
      end
      m_ready = !m_pending;
    end
  end

  // DUT-side log of consumed results and error pulses
  logic [31:0] res_val[$];
  logic [3:0]  res_cnt[$];
  int          n_err_seen = 0;
  always @(posedge clk) begin
    if (rst_n && number_valid && number_ready) begin
      res_val.push_back(number_out);
      res_cnt.push_back(digit_count);
    end
    if (rst_n && error) n_err_seen++;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!rst_n) begin
      check("rst_char_ready", {31'd0, char_ready}, 0);
      check("rst_number_valid", {31'd0, number_valid}, 0);
      check("rst_error", {31'd0, error}, 0);
      check("rst_number_out", number_out, 0);
      check("rst_digit_count", {28'd0, digit_count}, 0);
    end else begin
      check("char_ready", {31'd0, char_ready}, {31'd0, m_ready});
      check("number_valid", {31'd0, number_valid}, {31'd0, m_pending});
      check("error", {31'd0, error}, {31'd0, m_err});
      if (m_pending) begin
        check("number_out", number_out, m_out);
        check("digit_count", {28'd0, digit_count}, m_cnt);
      end
    end
    if (rnd_bp) number_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic idle(input int n);
    char_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_char(input logic [7:0] c);
    int t = 0;
    if (rnd_bp && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    char_in = c;
    char_valid = 1'b1;
    while (!char_ready && t < 64) begin tick(); t++; end
    if (!char_ready) check("char_ready_timeout", 0, 1);
    tick();
    char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  function automatic logic [7:0] rand_illegal();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255)); while (classify(c) != 17);
    return c;
  endfunction

  function automatic logic [7:0] rand_digit();
    string hc = "0123456789abcdefABCDEF";
    return hc[$urandom_range(0, 21)];
  endfunction

  function automatic logic [7:0] rand_term();
    case ($urandom_range(0, 2))
      0: return 8'h0D;
      1: return 8'h0A;
      default: return 8'h20;
    endcase
  endfunction

  task automatic rand_field();
    int kind = $urandom_range(0, 9);
    int len, bad;
    case (kind)
      6:       len = $urandom_range(MAX + 1, MAX + 3);
      7, 9:    len = $urandom_range(1, 4);
      8:       len = 0;
      default: len = $urandom_range(1, MAX);
    endcase
    bad = (kind == 9) ? 0 : $urandom_range(0, len);
    for (int i = 0; i < len; i++) begin
      if ((kind == 7 || kind == 9) && i == bad) send_char(rand_illegal());
      send_char(rand_digit());
    end
    send_char(rand_term());
  endtask

  int e0, r0;

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // "1aF3" CR, downstream always ready
    number_ready = 1'b1;
    r0 = res_val.size();
    send_str("1aF3\r");
    check("1aF3_valid", {31'd0, number_valid}, 1);
    check("1aF3_out", number_out, 32'h00001AF3);
    check("1aF3_cnt", {28'd0, digit_count}, 4);
    check("1aF3_model", m_out, 32'h00001AF3);
    idle(3);
    check("1aF3_nres", res_val.size(), r0 + 1);

    // "DEADBEEF" LF held under backpressure
    number_ready = 1'b0;
    send_str("DEADBEEF\n");
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'd0, number_valid}, 1);
      check("hold_out", number_out, 32'hDEADBEEF);
      check("hold_cnt", {28'd0, digit_count}, 8);
      check("hold_ready", {31'd0, char_ready}, 0);
      tick();
    end
    number_ready = 1'b1;
    tick();
    check("release_ready", {31'd0, char_ready}, 1);
    check("release_valid", {31'd0, number_valid}, 0);

    // nine digits overflow, then a fresh field
    e0 = n_err_seen; r0 = res_val.size();
    send_str("123456789 ");
    idle(3);
    check("ovf_err", n_err_seen - e0, 1);
    check("ovf_nres", res_val.size(), r0);
    send_str("7\r");
    idle(3);
    check("after_ovf_nres", res_val.size(), r0 + 1);
    check("after_ovf_val", res_val[$], 32'h7);
    check("after_ovf_cnt", {28'd0, res_cnt[$]}, 1);

    // illegal char inside a field; empty fields
    e0 = n_err_seen; r0 = res_val.size();
    send_str("12G4\r");
    idle(3);
    check("illegal_err", n_err_seen - e0, 1);
    check("illegal_nres", res_val.size(), r0);
    send_str("\r");
    send_str("  ");
    idle(3);
    check("empty_err", n_err_seen - e0, 1);
    check("empty_nres", res_val.size(), r0);

    // reset mid-field
    r0 = res_val.size();
    send_str("AB");
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_str("5\r");
    idle(3);
    check("rst_mid_nres", res_val.size(), r0 + 1);
    check("rst_mid_val", res_val[$], 32'h5);
    check("rst_mid_cnt", {28'd0, res_cnt[$]}, 1);

    // random fields with gaps and backpressure
    rnd_bp = 1'b1;
    for (int f = 0; f < 1000; f++) rand_field();
    rnd_bp = 1'b0;
    number_ready = 1'b1;
    idle(5);
    check("total_results", res_val.size(), m_nres);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
